// File: rtl/pulse_event_ctrl.sv
// Destination-domain consumer of synchronized event pulses: counts them and replays each as a req/ack handshake.
// Optional request abandonment after TIMEOUT_CYC unacknowledged cycles is built when PULSE_EVT_TIMEOUT_EN is defined.
module pulse_event_ctrl #(
    parameter int CNT_W       = 4,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             dst_clk,
    input  logic             dst_rst_n,
    input  logic             pulse_in,
    output logic             evt_req,
    input  logic             evt_ack,
    input  logic             clr_err,
    output logic [CNT_W-1:0] pending_cnt,
    output logic             overflow,
    output logic             timeout_err,
    output logic             busy
);

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_nxt;
    logic             cmpl;
    logic             tmo_fire;
    logic             dec;
    logic             ovf_set;
    logic [CNT_W-1:0] cnt_nxt;

    assign cmpl = evt_req & evt_ack;

`ifdef PULSE_EVT_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_fire = (state == REQ) && !evt_ack && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    // Counter is zero whenever REQ is entered, so it measures the current request only.
    always_ff @(posedge dst_clk or negedge dst_rst_n) begin
        if (!dst_rst_n) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if ((state == REQ) && !cmpl && !tmo_fire)
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            else
                tmo_cnt <= '0;
            timeout_err <= tmo_fire | (timeout_err & ~clr_err);
        end
    end
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;

    assign tmo_fire    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // An abandoned request consumes its event just like a completed one.
    assign dec     = cmpl | tmo_fire;
    assign ovf_set = pulse_in && !dec && (pending_cnt == CNT_MAX);

    always_comb begin
        cnt_nxt = pending_cnt;
        if (pulse_in && !dec && (pending_cnt != CNT_MAX))
            cnt_nxt = pending_cnt + CNT_W'(1);
        else if (!pulse_in && dec)
            cnt_nxt = pending_cnt - CNT_W'(1);
    end

    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        case (state)
            IDLE: begin
                if (pending_cnt != '0)
                    state_nxt = REQ;
            end
            REQ: begin
                if (dec) begin
                    state_nxt = GAP;
                    gap_nxt   = GAP_W'(GAP_CYC - 1);
                end
            end
            GAP: begin
                if (gap_cnt == '0)
                    state_nxt = IDLE;
                else
                    gap_nxt = gap_cnt - GAP_W'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // evt_req is registered from the next state so it is high exactly while state is REQ.
    always_ff @(posedge dst_clk or negedge dst_rst_n) begin
        if (!dst_rst_n) begin
            state       <= IDLE;
            gap_cnt     <= '0;
            evt_req     <= 1'b0;
            pending_cnt <= '0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_nxt;
            gap_cnt     <= gap_nxt;
            evt_req     <= (state_nxt == REQ);
            pending_cnt <= cnt_nxt;
            overflow    <= ovf_set | (overflow & ~clr_err);
        end
    end

    assign busy = (state != IDLE) || (pending_cnt != '0);

endmodule

// File: tb/tb_pulse_event_ctrl.sv
// Scoreboard bench for pulse_event_ctrl: expectations are queued with a due cycle as stimulus is driven.
module tb_pulse_event_ctrl;

    localparam int CNT_W = 4;

    localparam int S_REQ  = 0;
    localparam int S_CNT  = 1;
    localparam int S_OVF  = 2;
    localparam int S_TMO  = 3;
    localparam int S_BUSY = 4;

`ifdef PULSE_EVT_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic             dst_clk;
    logic             dst_rst_n;
    logic             pulse_in;
    logic             evt_req;
    logic             evt_ack;
    logic             clr_err;
    logic [CNT_W-1:0] pending_cnt;
    logic             overflow;
    logic             timeout_err;
    logic             busy;

    pulse_event_ctrl #(
        .CNT_W      (CNT_W),
        .GAP_CYC    (2),
        .TIMEOUT_CYC(16)
    ) dut (
        .dst_clk    (dst_clk),
        .dst_rst_n  (dst_rst_n),
        .pulse_in   (pulse_in),
        .evt_req    (evt_req),
        .evt_ack    (evt_ack),
        .clr_err    (clr_err),
        .pending_cnt(pending_cnt),
        .overflow   (overflow),
        .timeout_err(timeout_err),
        .busy       (busy)
    );

    initial dst_clk = 1'b0;
    always #5 dst_clk = ~dst_clk;

    typedef struct {
        int    cyc;
        int    sig;
        int    val;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    task automatic check_val(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int sig_val(input int sig);
        case (sig)
            S_REQ:   return int'(evt_req);
            S_CNT:   return int'(pending_cnt);
            S_OVF:   return int'(overflow);
            S_TMO:   return int'(timeout_err);
            default: return int'(busy);
        endcase
    endfunction

    task automatic push(input int c, input int sig, input int val, input string tag);
        exp_t e;
        e.cyc = c;
        e.sig = sig;
        e.val = val;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic sb_service();
        int i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                check_val($sformatf("%s@%0d", sb[i].tag, cyc), sig_val(sb[i].sig), sb[i].val);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    task automatic step();
        @(posedge dst_clk);
        #1;
        cyc++;
        sb_service();
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic apply_reset();
        dst_rst_n = 1'b0;
        pulse_in  = 1'b0;
        evt_ack   = 1'b0;
        clr_err   = 1'b0;
        @(posedge dst_clk);
        @(posedge dst_clk);
        #1;
        cyc = -1000;
        push(cyc, S_REQ,  0, "rst_req");
        push(cyc, S_CNT,  0, "rst_cnt");
        push(cyc, S_OVF,  0, "rst_ovf");
        push(cyc, S_TMO,  0, "rst_tmo");
        push(cyc, S_BUSY, 0, "rst_busy");
        sb_service();
        #3;
        dst_rst_n = 1'b1;
        @(posedge dst_clk);
        #1;
        cyc = 0;
    endtask

    initial begin
        dst_rst_n = 1'b0;
        pulse_in  = 1'b0;
        evt_ack   = 1'b0;
        clr_err   = 1'b0;

        // Single pulse, ack when request seen
        apply_reset();
        push(1, S_CNT, 1, "t1_cnt");
        push(1, S_REQ, 0, "t1_req");
        push(2, S_REQ, 1, "t1_req");
        push(3, S_REQ, 0, "t1_req");
        push(3, S_CNT, 0, "t1_cnt");
        push(3, S_BUSY, 1, "t1_busy");
        push(4, S_BUSY, 1, "t1_busy");
        push(5, S_BUSY, 0, "t1_busy");
        push(5, S_REQ, 0, "t1_req");
        pulse_in = 1'b1;
        step();
        pulse_in = 1'b0;
        step();
        evt_ack = evt_req;
        step();
        evt_ack = 1'b0;
        step_n(2);

        // Three back-to-back pulses with ack held high
        cyc = 0;
        for (int c = 1; c <= 11; c++)
            push(c, S_REQ, (c == 2 || c == 6 || c == 10) ? 1 : 0, "t2_req");
        push(1, S_CNT, 1, "t2_cnt");
        push(2, S_CNT, 2, "t2_cnt");
        push(3, S_CNT, 2, "t2_cnt");
        push(6, S_CNT, 2, "t2_cnt");
        push(7, S_CNT, 1, "t2_cnt");
        push(10, S_CNT, 1, "t2_cnt");
        push(11, S_CNT, 0, "t2_cnt");
        push(13, S_BUSY, 0, "t2_busy");
        evt_ack  = 1'b1;
        pulse_in = 1'b1;
        step_n(3);
        pulse_in = 1'b0;
        step_n(8);
        evt_ack = 1'b0;
        step_n(2);

        // Saturation, overflow sticky and clear priority
        apply_reset();
        push(15, S_CNT, 15, "t3_cnt");
        push(15, S_OVF, 0, "t3_ovf");
        push(16, S_CNT, 15, "t3_cnt");
        push(16, S_OVF, 1, "t3_ovf");
        push(17, S_CNT, 15, "t3_cnt");
        push(17, S_OVF, 1, "t3_ovf_setwins");
        push(18, S_OVF, 0, "t3_ovf_clr");
        push(18, S_CNT, TMO_EN ? 14 : 15, "t3_cnt");
        push(18, S_TMO, TMO_EN ? 1 : 0, "t3_tmo");
        pulse_in = 1'b1;
        step_n(16);
        clr_err = 1'b1;
        step();
        pulse_in = 1'b0;
        step();
        clr_err = 1'b0;

        // Pulse and completion in the same cycle
        apply_reset();
        push(5, S_CNT, 5, "t4_cnt");
        push(5, S_REQ, 1, "t4_req");
        push(6, S_CNT, 5, "t4_cnt");
        push(6, S_REQ, 0, "t4_req");
        push(6, S_BUSY, 1, "t4_busy");
        push(7, S_REQ, 0, "t4_req");
        push(8, S_REQ, 0, "t4_req");
        push(9, S_REQ, 1, "t4_req");
        push(9, S_CNT, 5, "t4_cnt");
        pulse_in = 1'b1;
        step_n(5);
        evt_ack = 1'b1;
        step();
        pulse_in = 1'b0;
        evt_ack  = 1'b0;
        step_n(3);

        // Asynchronous reset in the middle of a request
        apply_reset();
        push(3, S_CNT, 3, "t5_cnt");
        push(3, S_REQ, 1, "t5_req");
        pulse_in = 1'b1;
        step_n(3);
        pulse_in = 1'b0;
        #2;
        dst_rst_n = 1'b0;
        #1;
        push(cyc, S_REQ, 0, "t5_async_req");
        push(cyc, S_CNT, 0, "t5_async_cnt");
        push(cyc, S_BUSY, 0, "t5_async_busy");
        sb_service();
        #2;
        dst_rst_n = 1'b1;
        for (int c = 4; c <= 8; c++) begin
            push(c, S_REQ, 0, "t5_idle_req");
            push(c, S_BUSY, 0, "t5_idle_busy");
        end
        push(9, S_CNT, 1, "t5_cnt");
        push(10, S_REQ, 1, "t5_req");
        step_n(5);
        pulse_in = 1'b1;
        step();
        pulse_in = 1'b0;
        step();

        // Unacknowledged request
        apply_reset();
        for (int c = 2; c <= 17; c++)
            push(c, S_REQ, 1, "t6_req");
        push(17, S_TMO, 0, "t6_tmo");
        push(18, S_REQ, TMO_EN ? 0 : 1, "t6_req");
        push(18, S_TMO, TMO_EN ? 1 : 0, "t6_tmo");
        push(18, S_CNT, TMO_EN ? 0 : 1, "t6_cnt");
        push(19, S_TMO, 0, "t6_tmo_clr");
        pulse_in = 1'b1;
        step();
        pulse_in = 1'b0;
        step_n(17);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;

        check_val("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
